// File: rtl/decode_issue.sv
// decode_issue: RV32I integer decode, scoreboarded operand read and registered ALU issue
module decode_issue #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [31:0]     in_pc,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [2:0]      alu_mode,
   output logic [4:0]      out_rd,
   output logic            illegal
);
   logic [6:0]      opc, f7;
   logic [2:0]      f3;
   logic [4:0]      rd, rs1, rs2;
   logic [XLEN-1:0] rs1_v, rs2_v;
   logic            dec_legal, use_rs1, use_rs2, stall, accept, issue;
   logic [2:0]      dec_mode;
   logic [XLEN-1:0] dec_a, dec_b;
   logic [XLEN-1:0] rf_q [32];
   logic [XLEN-1:0] rf_d [32];
   logic [31:0]     pend_q, pend_d;
   logic            out_valid_q, out_valid_d, illegal_q, illegal_d;
   logic [XLEN-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [2:0]      alu_mode_q, alu_mode_d;
   logic [4:0]      out_rd_q, out_rd_d;

   assign opc = in_instr[6:0];
   assign rd  = in_instr[11:7];
   assign f3  = in_instr[14:12];
   assign rs1 = in_instr[19:15];
   assign rs2 = in_instr[24:20];
   assign f7  = in_instr[31:25];

   // operand read with same-cycle writeback bypass; x0 always reads zero
   assign rs1_v = (rs1 == 5'd0) ? '0 : (wb_en && wb_rd == rs1) ? wb_data : rf_q[rs1];
   assign rs2_v = (rs2 == 5'd0) ? '0 : (wb_en && wb_rd == rs2) ? wb_data : rf_q[rs2];

   // decode opcode/funct fields into legality, ALU mode and operands
   always_comb begin
      dec_legal = 1'b0;
      dec_mode  = 3'b000;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      dec_a     = rs1_v;
      dec_b     = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
      case (opc)
         7'b0110011: begin
            use_rs1   = 1'b1;
            use_rs2   = 1'b1;
            dec_b     = rs2_v;
            dec_legal = (f7 == 7'h00 && f3 != 3'b010 && f3 != 3'b011) ||
                        (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
            dec_mode  = (f7 != 7'h20) ? f3 : (f3 == 3'b000) ? 3'b010 : 3'b011;
         end
         7'b0010011: begin
            use_rs1   = 1'b1;
            dec_legal = (f3 == 3'b001) ? (f7 == 7'h00) :
                        (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) :
                        (f3 != 3'b010 && f3 != 3'b011);
            dec_mode  = (f3 == 3'b101 && f7 == 7'h20) ? 3'b011 : f3;
            if (f3 == 3'b001 || f3 == 3'b101)
               dec_b = {{(XLEN-5){1'b0}}, in_instr[24:20]};
         end
         7'b0110111: begin
            dec_legal = 1'b1;
            dec_a     = '0;
            dec_b     = {in_instr[31:12], 12'b0};
         end
         7'b0010111: begin
            dec_legal = 1'b1;
            dec_a     = in_pc;
            dec_b     = {in_instr[31:12], 12'b0};
         end
         default: dec_legal = 1'b0;
      endcase
   end

   // RAW on used sources unless bypassed, WAW on rd unless its clear arrives now
   assign stall = dec_legal && (
                  (use_rs1 && pend_q[rs1] && !(wb_en && wb_rd == rs1)) ||
                  (use_rs2 && pend_q[rs2] && !(wb_en && wb_rd == rs2)) ||
                  (rd != 5'd0 && pend_q[rd] && !(wb_en && wb_rd == rd)));
   assign in_ready = !stall && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign issue    = accept && dec_legal;

   // next state for register file, scoreboard, output register and sticky flag
   always_comb begin
      rf_d = rf_q;
      if (wb_en && wb_rd != 5'd0)
         rf_d[wb_rd] = wb_data;
      pend_d = pend_q;
      if (wb_en)
         pend_d[wb_rd] = 1'b0;
      if (issue && rd != 5'd0)
         pend_d[rd] = 1'b1;
      pend_d[0]   = 1'b0;
      out_valid_d = issue ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
      alu_a_d     = issue ? dec_a : alu_a_q;
      alu_b_d     = issue ? dec_b : alu_b_q;
      alu_mode_d  = issue ? dec_mode : alu_mode_q;
      out_rd_d    = issue ? rd : out_rd_q;
      illegal_d   = illegal_q || (accept && !dec_legal);
   end

   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
         pend_q      <= '0;
         out_valid_q <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_mode_q  <= 3'b000;
         out_rd_q    <= 5'd0;
         illegal_q   <= 1'b0;
      end else begin
         rf_q        <= rf_d;
         pend_q      <= pend_d;
         out_valid_q <= out_valid_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_mode_q  <= alu_mode_d;
         out_rd_q    <= out_rd_d;
         illegal_q   <= illegal_d;
      end
   end

   assign out_valid = out_valid_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_mode  = alu_mode_q;
   assign out_rd    = out_rd_q;
   assign illegal   = illegal_q;
endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed vector table plus reset-mid-stream sequence for decode_issue
module tb_decode_issue;
   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, wb_en, out_valid, out_ready, illegal;
   logic [31:0] in_instr, in_pc, wb_data, alu_a, alu_b;
   logic [4:0]  wb_rd, out_rd;
   logic [2:0]  alu_mode;
   int          total = 0, bad = 0;

   typedef struct {
      logic        v;
      logic [31:0] instr, pc;
      logic        we;
      logic [4:0]  wrd;
      logic [31:0] wd;
      logic        ordy;
      logic        e_rdy, e_val;
      logic [31:0] e_a, e_b;
      logic [2:0]  e_mode;
      logic [4:0]  e_rd;
      logic        e_ill;
   } vec_t;

   vec_t vt [19];

   decode_issue dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .wb_en(wb_en), .wb_rd(wb_rd),
      .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .out_rd(out_rd),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] s2,
                                       input logic [4:0] s1, input logic [2:0] f3,
                                       input logic [4:0] d);
      return {f7, s2, s1, f3, d, 7'b0110011};
   endfunction

   function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] s1,
                                       input logic [2:0] f3, input logic [4:0] d);
      return {imm, s1, f3, d, 7'b0010011};
   endfunction

   function automatic vec_t mk(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                               input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                               input logic ordy, input logic e_rdy, input logic e_val,
                               input logic [31:0] e_a, input logic [31:0] e_b,
                               input logic [2:0] e_mode, input logic [4:0] e_rd,
                               input logic e_ill);
      vec_t t;
      t.v = v; t.instr = instr; t.pc = pc; t.we = we; t.wrd = wrd; t.wd = wd;
      t.ordy = ordy; t.e_rdy = e_rdy; t.e_val = e_val; t.e_a = e_a; t.e_b = e_b;
      t.e_mode = e_mode; t.e_rd = e_rd; t.e_ill = e_ill;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                        input logic ordy);
      in_valid = v; in_instr = instr; in_pc = pc;
      wb_en = we; wb_rd = wrd; wb_data = wd; out_ready = ordy;
   endtask

   task automatic check_out(input string tag, input logic e_val, input logic [31:0] e_a,
                            input logic [31:0] e_b, input logic [2:0] e_mode,
                            input logic [4:0] e_rd, input logic e_ill);
      check({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, e_val});
      check({tag, " alu_a"}, alu_a, e_a);
      check({tag, " alu_b"}, alu_b, e_b);
      check({tag, " alu_mode"}, {29'b0, alu_mode}, {29'b0, e_mode});
      check({tag, " out_rd"}, {27'b0, out_rd}, {27'b0, e_rd});
      check({tag, " illegal"}, {31'b0, illegal}, {31'b0, e_ill});
   endtask

   initial begin
      vt[0]  = mk(0, 32'h0, 0, 1, 5'd1, 32'd5, 1, 1, 0, 0, 0, 3'd0, 0, 0);
      vt[1]  = mk(0, 32'h0, 0, 1, 5'd2, 32'd7, 1, 1, 0, 0, 0, 3'd0, 0, 0);
      vt[2]  = mk(1, r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 0, 0, 0, 0, 1, 1, 1, 5, 7, 3'b000, 3, 0);
      vt[3]  = mk(1, r_t(7'h20, 5'd1, 5'd1, 3'b000, 5'd4), 0, 0, 0, 0, 1, 1, 1, 5, 5, 3'b010, 4, 0);
      vt[4]  = mk(1, i_t(12'h403, 5'd1, 3'b101, 5'd5), 0, 0, 0, 0, 1, 1, 1, 5, 3, 3'b011, 5, 0);
      vt[5]  = mk(1, i_t(12'hfff, 5'd0, 3'b000, 5'd6), 0, 0, 0, 0, 1, 1, 1, 0, 32'hffffffff, 3'b000, 6, 0);
      vt[6]  = mk(1, i_t(12'h001, 5'd0, 3'b000, 5'd7), 0, 0, 0, 0, 1, 1, 1, 0, 1, 3'b000, 7, 0);
      vt[7]  = mk(1, r_t(7'h00, 5'd7, 5'd7, 3'b000, 5'd8), 0, 0, 0, 0, 1, 0, 0, 0, 1, 3'b000, 7, 0);
      vt[8]  = mk(1, r_t(7'h00, 5'd7, 5'd7, 3'b000, 5'd8), 0, 1, 5'd7, 32'd9, 1, 1, 1, 9, 9, 3'b000, 8, 0);
      vt[9]  = mk(1, r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd9), 0, 0, 0, 0, 0, 0, 1, 9, 9, 3'b000, 8, 0);
      vt[10] = vt[9];
      vt[11] = vt[9];
      vt[12] = mk(1, r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd9), 0, 0, 0, 0, 1, 1, 1, 5, 7, 3'b000, 9, 0);
      vt[13] = mk(1, r_t(7'h00, 5'd2, 5'd1, 3'b010, 5'd10), 0, 0, 0, 0, 1, 1, 0, 5, 7, 3'b000, 9, 1);
      vt[14] = mk(1, 32'h0000_2003, 0, 0, 0, 0, 1, 1, 0, 5, 7, 3'b000, 9, 1);
      vt[15] = mk(1, {20'h12345, 5'd9, 7'b0110111}, 0, 1, 5'd9, 32'h55, 1, 1, 1, 0, 32'h12345000, 3'b000, 9, 1);
      vt[16] = mk(1, {20'h00001, 5'd11, 7'b0010111}, 32'h100, 0, 0, 0, 1, 1, 1, 32'h100, 32'h1000, 3'b000, 11, 1);
      vt[17] = mk(1, i_t(12'h002, 5'd0, 3'b000, 5'd9), 0, 0, 0, 0, 1, 0, 0, 32'h100, 32'h1000, 3'b000, 11, 1);
      vt[18] = mk(1, i_t(12'h401, 5'd1, 3'b001, 5'd12), 0, 0, 0, 0, 1, 1, 0, 32'h100, 32'h1000, 3'b000, 11, 1);

      rst_n = 1'b0;
      drive(0, 32'h0, 0, 0, 0, 0, 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_out("reset", 0, 0, 0, 3'd0, 0, 0);
      check("reset in_ready", {31'b0, in_ready}, 32'd1);
      rst_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         drive(vt[i].v, vt[i].instr, vt[i].pc, vt[i].we, vt[i].wrd, vt[i].wd, vt[i].ordy);
         #1;
         check($sformatf("v%0d in_ready", i), {31'b0, in_ready}, {31'b0, vt[i].e_rdy});
         @(posedge clk);
         #1;
         check_out($sformatf("v%0d", i), vt[i].e_val, vt[i].e_a, vt[i].e_b,
                   vt[i].e_mode, vt[i].e_rd, vt[i].e_ill);
         @(negedge clk);
      end

      drive(1, i_t(12'h003, 5'd0, 3'b000, 5'd1), 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check("pre-reset out_valid", {31'b0, out_valid}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      drive(0, 32'h0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check_out("midreset", 0, 0, 0, 3'd0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, r_t(7'h00, 5'd1, 5'd1, 3'b000, 5'd2), 0, 0, 0, 0, 1);
      #1;
      check("post-reset in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      check_out("post-reset", 1, 0, 0, 3'b000, 2, 0);
      @(negedge clk);
      in_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/decode_issue.md
# decode_issue

Decode-and-issue stage sitting directly upstream of the 32-bit execute ALU. It accepts RV32I integer instructions from fetch, reads operands from an internal 32×32 register file, resolves read-after-write hazards with a per-register scoreboard, and presents registered `alu_a`/`alu_b`/`alu_mode` plus destination info to the ALU stage over a valid/ready handshake. Results return through a writeback port that updates the register file and clears the scoreboard.

## Interface
- `XLEN`, 32: operand/register width; fixed at 32 in this revision.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: fetch presents an instruction.
- `in_ready` output 1: stage accepts the instruction this cycle.
- `in_instr` input 32: instruction word.
- `in_pc` input 32: instruction address, used by AUIPC.
- `wb_en` input 1: writeback strobe.
- `wb_rd` input 5: writeback destination.
- `wb_data` input 32: writeback value.
- `out_valid` output 1: issued op valid.
- `out_ready` input 1: ALU stage accepts the op.
- `alu_a` output 32: first operand.
- `alu_b` output 32: second operand.
- `alu_mode` output 3: ALU op (000 add, 001 sll, 010 sub, 011 sra, 100 xor, 101 srl, 110 or, 111 and).
- `out_rd` output 5: destination register; 0 means no write.
- `illegal` output 1: sticky flag, set on any unsupported instruction.

## Operation
- Accepted opcodes:
  - OP (0110011): funct3/funct7 000/00→000, 000/20→010, 001/00→001, 100/00→100, 101/00→101, 101/20→011, 110/00→110, 111/00→111.
  - OP-IMM (0010011): same funct3 map with `b` = sign-extended I-immediate. ADDI ignores bit 30. SLLI/SRLI/SRAI use shamt = instr[24:20] and require instr[31:25] = 00 or 20 (SRAI only).
  - LUI: `a`=0, `b`={instr[31:12],12'b0}, mode 000.
  - AUIPC: `a`=`in_pc`, `b`=U-immediate, mode 000.
- Illegal instructions: every other opcode, plus SLT/SLTU (funct3 010/011) and bad funct7. An illegal instruction is consumed (`in_ready`=1 if not stalled), nothing is issued, and `illegal` is set until reset.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Written at the clock edge when `wb_en` is high.
  - Same-cycle bypass: if `wb_en` and `wb_rd`==rs≠0, the operand takes `wb_data`.
- Scoreboard: 32 pending bits, bit 0 always 0.
  - Issuing an op with rd≠0 sets pending[rd]; `wb_en` clears pending[`wb_rd`].
  - Same rd set and cleared in one cycle: set wins.
- Hazard stall: the decoded instruction stalls while either of the following holds.
  - Any used source rs is pending and not being bypassed this cycle.
  - Its rd≠0 is pending (WAW), with no clear arriving this cycle.
- Unused rs fields (LUI/AUIPC rs1/rs2, OP-IMM rs2) never cause a stall.
- Handshake: `in_ready` = !stall && (!out_valid || out_ready). Accepting a legal instruction loads the output register and sets `out_valid`. `out_valid` clears on `out_ready` with no new accept. Outputs hold stable while `out_valid` && !`out_ready`.

## Timing
- Reset values: `out_valid`=0, `alu_a`=`alu_b`=0, `alu_mode`=000, `out_rd`=0, `illegal`=0, all registers 0, all pending bits 0. `in_ready` is combinational and is 1 out of reset.
- Latency: the instruction is accepted at edge N and the op is visible with `out_valid` after edge N.
- Throughput: one op per cycle when unstalled and `out_ready`=1.
- Writeback at edge N is visible to the register file read from cycle N+1, and to the bypass in cycle N.
- Reset asserted mid-stream: the in-flight output op is discarded, the scoreboard is cleared, and the register file is cleared on the same edge.
- `in_ready` may depend combinationally on `in_instr`, `wb_*` and `out_ready`. No output depends combinationally on `in_valid`.

## Test plan
- Reset, then write x1=5 via wb. Issue `add x3,x1,x2` with x2=7 → `alu_a`=5, `alu_b`=7, mode 000, `out_rd`=3, `out_valid` one cycle after accept.
- `sub x4,x1,x1`, then `srai x5,x1,3` → modes 010 and 011. SRAI gives `alu_b`=3. `addi x6,x0,-1` gives `alu_b`=FFFFFFFF.
- Issue `addi x7,x0,1`, then `add x8,x7,x7` with no writeback → `in_ready`=0 for the second instruction. Assert `wb_en`, `wb_rd`=7, `wb_data`=9 → accepted in that cycle with `alu_a`=`alu_b`=9.
- Hold `out_ready`=0 for 3 cycles with valid input → `out_valid` stays 1, outputs stay stable, `in_ready`=0. Release → next op issues on the following edge.
- Present `slt` and then opcode 0000011 → both consumed, no `out_valid`, `illegal`=1 after the first. `lui x9,0x12345` → `alu_b`=12345000.
- Drop `rst_n` while `out_valid`=1 and x1 is pending → next cycle `out_valid`=0. `add x2,x1,x1` issues without stall with `alu_a`=0.
